serial_pattern_detector: RTL and testbench
==========================================

SERIAL_PATTERN_DETECTOR -- requirements
Module: serial_pattern_detector

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the parallel word width in bits (2..32).
REQ-002 Parameter PAT_W, default 4, SHALL set the pattern length in bits (1..DATA_W).
REQ-003 Parameter PATTERN, default 4'b1101, SHALL set the PAT_W-bit target sequence, first-received bit in the MSB.
REQ-004 Parameter OVERLAP, default 1, SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-005 Parameter CNT_W, default 16, SHALL set the match counter width.
REQ-006 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 step  in  1  single-cycle bit-advance strobe (e.g. debounced key pulse).
REQ-009 load_valid  in  1  request to load load_data.
REQ-010 load_data  in  DATA_W  parallel word to serialise.
REQ-011 load_ready  out  1  high when the shifter accepts a load.
REQ-012 clr_cnt  in  1  synchronous clear of match_cnt.
REQ-013 ser_bit  out  1  current serial bit, MSB first.
REQ-014 ser_valid  out  1  ser_bit holds a valid word bit.
REQ-015 match  out  1  one-cycle pulse per detected pattern.
REQ-016 match_cnt  out  CNT_W  saturating count of matches.

Function
REQ-017 load_ready SHALL equal !ser_valid; a load SHALL occur on a cycle with load_valid && load_ready.
REQ-018 On load, the word SHALL be captured, ser_valid SHALL go 1 on the next cycle, and ser_bit SHALL present bit DATA_W-1.
REQ-019 Each step while ser_valid SHALL feed ser_bit to the matcher and advance to the next lower bit; a step while !ser_valid SHALL be ignored.
REQ-020 After the step that consumes bit 0, ser_valid SHALL drop on the next cycle (one-shot mode).
REQ-021 The matcher SHALL keep a PAT_W-bit history and a fill count saturating at PAT_W; a match SHALL require fill == PAT_W and history == PATTERN.
REQ-022 match SHALL be registered and high for exactly the one cycle after the matching step.
REQ-023 With OVERLAP=0, the fill count SHALL clear on a match; with OVERLAP=1, history and fill SHALL be retained.
REQ-024 History and fill SHALL persist across word boundaries, so patterns spanning two words SHALL be detected.
REQ-025 match_cnt SHALL increment on each match and hold at 2^CNT_W-1.
REQ-026 When clr_cnt and a match coincide, clr_cnt SHALL win and match_cnt SHALL become 0; the match pulse SHALL still be issued.

Reset
REQ-027 While rst=0, ser_bit, ser_valid, match, match_cnt, history, fill and the bit index SHALL be 0, and load_ready SHALL be 1.
REQ-028 A reset mid-word SHALL discard the remaining bits, and no match SHALL be issued for a step in the reset cycle.

Configuration
REQ-029 The macro SPD_CIRCULAR_EN, when defined, SHALL make the shifter rotate: after bit 0, bit DATA_W-1 of the same word follows, ser_valid stays 1, and load_ready is 1 only at a word boundary (index = DATA_W-1).
REQ-030 Without SPD_CIRCULAR_EN, the shifter SHALL behave one-shot per REQ-020.

Structure
REQ-031 Package spd_pkg SHALL hold the default widths, the default pattern constant and the index/fill width functions.
REQ-032 The history/fill/compare logic SHALL be a sub-module spd_matcher, instantiated once.

Verification
REQ-033 Load 8'hD1 and apply 8 steps, defaults -> one match after step 4, match_cnt=1, then ser_valid=0.
REQ-034 Load 8'hDB, OVERLAP=1, 8 steps -> matches after steps 4 and 7, match_cnt=2; with OVERLAP=0 -> match_cnt=1.
REQ-035 With rst=0 asserted after step 3 of 8'hD1 -> all outputs 0 and load_ready=1 immediately; no match follows.
REQ-036 With CNT_W=2, five words of 8'hD1 -> match_cnt saturates at 3; clr_cnt coincident with a match -> match_cnt=0.
REQ-037 With SPD_CIRCULAR_EN, load 8'hD1 and apply 16 steps -> matches after steps 4 and 12, match_cnt=2, ser_valid stays 1.

Source files
------------

// File: rtl/spd_pkg.sv
// Shared constants, types and width helpers for serial_pattern_detector.
package spd_pkg;

  localparam int unsigned SPD_DATA_W = 8;
  localparam int unsigned SPD_PAT_W  = 4;
  localparam int unsigned SPD_CNT_W  = 16;
  localparam logic [SPD_PAT_W-1:0] SPD_PATTERN = 4'b1101;

  // Shifter control states
  typedef enum logic {
    SHIFT_IDLE = 1'b0,
    SHIFT_RUN  = 1'b1
  } shift_state_e;

  // One consumed serial bit handed from the shifter to the matcher
  typedef struct packed {
    logic valid;
    logic value;
  } spd_bit_t;

  // Bits needed to index a word of data_w bits
  function automatic int unsigned spd_idx_w(input int unsigned data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  // Bits needed to hold a fill count of 0..pat_w
  function automatic int unsigned spd_fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/spd_matcher.sv
// Pattern matcher: bit history, saturating fill count, match pulse and match counter.
module spd_matcher
  import spd_pkg::*;
#(
  parameter int unsigned       PAT_W   = SPD_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(SPD_PATTERN),
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = SPD_CNT_W
)(
  input  logic             clk,
  input  logic             rst,
  input  spd_bit_t         feed,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned      FILL_W    = spd_fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_d;
  logic [CNT_W-1:0]  cnt_d;

  // Next history/fill, match decision and counter update
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = match_cnt;
    if (feed.valid) begin
      hist_d  = PAT_W'({hist_q, feed.value});
      fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      match_d = (fill_d == FILL_FULL) && (hist_d == PATTERN);
      // Non-overlapping mode needs a full fresh window after each match
      if (match_d && !OVERLAP) begin
        fill_d = '0;
      end
    end
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match_d && (match_cnt != {CNT_W{1'b1}})) begin
      cnt_d = match_cnt + CNT_W'(1);
    end
  end

  // Matcher state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match     <= match_d;
      match_cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serialises a loaded word MSB first on step strobes and counts occurrences of PATTERN.
// Optional build macro SPD_CIRCULAR_EN makes the shifter rotate the word instead of
// going idle after bit 0.
module serial_pattern_detector
  import spd_pkg::*;
#(
  parameter int unsigned       DATA_W  = SPD_DATA_W,
  parameter int unsigned       PAT_W   = SPD_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(SPD_PATTERN),
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = SPD_CNT_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              clr_cnt,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int unsigned       IDX_W   = spd_idx_w(DATA_W);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(DATA_W - 1);

  shift_state_e      state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ser_bit_d;
  logic              ser_valid_d;
  logic              load_ready_d;
  spd_bit_t          feed_c;

  // Shifter next-state: load, advance on step, wrap or go idle after bit 0
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    ser_bit_d    = ser_bit;
    ser_valid_d  = ser_valid;
    load_ready_d = load_ready;
    feed_c       = '0;
    case (state_q)
      SHIFT_IDLE: begin
        if (load_valid && load_ready) begin
          state_d     = SHIFT_RUN;
          word_d      = load_data;
          idx_d       = IDX_TOP;
          ser_bit_d   = load_data[DATA_W-1];
          ser_valid_d = 1'b1;
`ifdef SPD_CIRCULAR_EN
          load_ready_d = 1'b1;
`else
          load_ready_d = 1'b0;
`endif
        end
      end
      SHIFT_RUN: begin
        if (step) begin
          feed_c.valid = 1'b1;
          feed_c.value = ser_bit;
          if (idx_q == '0) begin
`ifdef SPD_CIRCULAR_EN
            idx_d        = IDX_TOP;
            ser_bit_d    = word_q[DATA_W-1];
            load_ready_d = 1'b1;
`else
            state_d      = SHIFT_IDLE;
            idx_d        = '0;
            ser_bit_d    = 1'b0;
            ser_valid_d  = 1'b0;
            load_ready_d = 1'b1;
`endif
          end else begin
            idx_d        = idx_q - IDX_W'(1);
            ser_bit_d    = word_q[idx_q - IDX_W'(1)];
            load_ready_d = 1'b0;
          end
        end
`ifdef SPD_CIRCULAR_EN
        // At a word boundary a new word replaces the rotating one
        if (load_valid && load_ready) begin
          word_d       = load_data;
          idx_d        = IDX_TOP;
          ser_bit_d    = load_data[DATA_W-1];
          load_ready_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = SHIFT_IDLE;
      end
    endcase
  end

  // Shifter registers; reset discards any partially sent word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SHIFT_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      ser_bit    <= ser_bit_d;
      ser_valid  <= ser_valid_d;
      load_ready <= load_ready_d;
    end
  end

  spd_matcher #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .CNT_W   (CNT_W)
  ) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .feed      (feed_c),
    .clr_cnt   (clr_cnt),
    .match     (match),
    .match_cnt (match_cnt)
  );

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Randomised and directed bench for serial_pattern_detector: two instances
// (overlapping/16-bit counter and non-overlapping/2-bit counter) share one stimulus.
module tb_serial_pattern_detector;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_A  = 16;
  localparam int unsigned CNT_B  = 2;
  localparam int          MAX_A  = 65535;
  localparam int          MAX_B  = 3;
  localparam logic [PAT_W-1:0] PAT = 4'b1101;
`ifdef SPD_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              step = 1'b0;
  logic              load_valid = 1'b0;
  logic              clr_cnt = 1'b0;
  logic [DATA_W-1:0] load_data = '0;

  logic             ser_bit_a, ser_valid_a, load_ready_a, match_a;
  logic [CNT_A-1:0] match_cnt_a;
  logic             ser_bit_b, ser_valid_b, load_ready_b, match_b;
  logic [CNT_B-1:0] match_cnt_b;

  always #5 clk = ~clk;

  serial_pattern_detector #(
    .DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(CNT_A)
  ) dut_a (
    .clk(clk), .rst(rst), .step(step), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_a), .clr_cnt(clr_cnt), .ser_bit(ser_bit_a),
    .ser_valid(ser_valid_a), .match(match_a), .match_cnt(match_cnt_a)
  );

  serial_pattern_detector #(
    .DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(CNT_B)
  ) dut_b (
    .clk(clk), .rst(rst), .step(step), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_b), .clr_cnt(clr_cnt), .ser_bit(ser_bit_b),
    .ser_valid(ser_valid_b), .match(match_b), .match_cnt(match_cnt_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining word bits as a queue, recent consumed bits, match bookkeeping
  bit q[$];
  bit fed[$];
  int pos;
  int n_fed;
  int last_b;
  bit em_a, em_b;
  int ec_a, ec_b;

  function automatic bit tail_matches();
    if (fed.size() < PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++)
      if (fed[fed.size() - PAT_W + i] != PAT[PAT_W-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    if (CIRC) return (q.size() == 0) || (pos == 0);
    return q.size() == 0;
  endfunction

  task automatic model_reset();
    q.delete(); fed.delete();
    pos = 0; n_fed = 0; last_b = 0;
    em_a = 1'b0; em_b = 1'b0; ec_a = 0; ec_b = 0;
  endtask

  task automatic model_edge(input bit lv, input logic [DATA_W-1:0] ld, input bit st, input bit clr);
    bit v, rdy, b, m;
    v   = q.size() > 0;
    rdy = model_ready();
    em_a = 1'b0; em_b = 1'b0;
    if (st && v) begin
      b = q.pop_front();
      if (CIRC) q.push_back(b);
      pos = (pos + 1) % DATA_W;
      fed.push_back(b);
      n_fed++;
      if (fed.size() > PAT_W) void'(fed.pop_front());
      m = tail_matches();
      em_a = m;
      if (m && (n_fed - last_b >= PAT_W)) begin
        em_b = 1'b1;
        last_b = n_fed;
      end
    end
    if (lv && rdy) begin
      q.delete();
      for (int i = DATA_W - 1; i >= 0; i--) q.push_back(ld[i]);
      pos = 0;
    end
    if (clr) begin
      ec_a = 0; ec_b = 0;
    end else begin
      if (em_a && ec_a < MAX_A) ec_a++;
      if (em_b && ec_b < MAX_B) ec_b++;
    end
  endtask

  task automatic compare_all();
    bit ev, eb, er;
    ev = q.size() > 0;
    eb = ev ? q[0] : 1'b0;
    er = model_ready();
    check("ser_valid_a", 32'(ser_valid_a), 32'(ev));
    check("ser_bit_a", 32'(ser_bit_a), 32'(eb));
    check("load_ready_a", 32'(load_ready_a), 32'(er));
    check("match_a", 32'(match_a), 32'(em_a));
    check("match_cnt_a", 32'(match_cnt_a), ec_a);
    check("ser_valid_b", 32'(ser_valid_b), 32'(ev));
    check("ser_bit_b", 32'(ser_bit_b), 32'(eb));
    check("load_ready_b", 32'(load_ready_b), 32'(er));
    check("match_b", 32'(match_b), 32'(em_b));
    check("match_cnt_b", 32'(match_cnt_b), ec_b);
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later
  task automatic tick(input bit lv, input logic [DATA_W-1:0] ld, input bit st, input bit clr);
    load_valid = lv; load_data = ld; step = st; clr_cnt = clr;
    @(posedge clk);
    model_edge(lv, ld, st, clr);
    #1;
    compare_all();
    load_valid = 1'b0; step = 1'b0; clr_cnt = 1'b0;
  endtask

  // Asynchronous reset asserted between edges, with a step pending in the reset cycle
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_ser_valid"}, 32'(ser_valid_a | ser_valid_b), 32'd0);
    check({tag, "_ser_bit"}, 32'(ser_bit_a | ser_bit_b), 32'd0);
    check({tag, "_match"}, 32'(match_a | match_b), 32'd0);
    check({tag, "_cnt"}, 32'(match_cnt_a) + 32'(match_cnt_b), 32'd0);
    check({tag, "_load_ready"}, 32'(load_ready_a & load_ready_b), 32'd1);
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    check({tag, "_match_in_reset"}, 32'(match_a | match_b), 32'd0);
    rst = 1'b1;
  endtask

  task automatic load_and_step(input logic [DATA_W-1:0] w, input int n);
    tick(1'b1, w, 1'b0, 1'b0);
    for (int s = 0; s < n; s++) tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_load_ready", 32'(load_ready_a), 32'd1);
    check("por_ser_valid", 32'(ser_valid_a), 32'd0);
    rst = 1'b1;

    // Single word 0xD1: one match after the fourth step
    do_reset("rst1");
    tick(1'b1, 8'hD1, 1'b0, 1'b0);
    for (int s = 1; s <= DATA_W; s++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      if (s == 4) check("d1_match_step4", 32'(match_a), 32'd1);
      if (s == 5) check("d1_match_step5", 32'(match_a), 32'd0);
    end
    check("d1_cnt", 32'(match_cnt_a), 32'd1);
    if (!CIRC) check("d1_ser_valid_end", 32'(ser_valid_a), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0);

    // 0xDB: overlapping finds two, non-overlapping one
    do_reset("rst2");
    load_and_step(8'hDB, DATA_W);
    check("db_cnt_overlap", 32'(match_cnt_a), 32'd2);
    check("db_cnt_nonoverlap", 32'(match_cnt_b), 32'd1);

    // Reset mid-word discards remaining bits and suppresses the pending match
    do_reset("rst3");
    load_and_step(8'hD1, 3);
    do_reset("midword");
    for (int s = 0; s < 3; s++) tick(1'b0, '0, 1'b1, 1'b0);
    check("midword_no_match_cnt", 32'(match_cnt_a), 32'd0);

    // Five words spanning boundaries: 2-bit counter saturates at 3
    do_reset("rst4");
    for (int w = 0; w < 5; w++) load_and_step(8'hD1, DATA_W);
    check("sat_cnt_a", 32'(match_cnt_a), 32'd5);
    check("sat_cnt_b", 32'(match_cnt_b), 32'd3);
    load_and_step(8'hD1, 3);
    tick(1'b0, '0, 1'b1, 1'b1);
    check("clr_win_match", 32'(match_a), 32'd1);
    check("clr_win_cnt_a", 32'(match_cnt_a), 32'd0);
    check("clr_win_cnt_b", 32'(match_cnt_b), 32'd0);

`ifdef SPD_CIRCULAR_EN
    // Rotating word: matches after steps 4 and 12, shifter stays valid
    do_reset("rst5");
    load_and_step(8'hD1, 16);
    check("circ_cnt", 32'(match_cnt_a), 32'd2);
    check("circ_ser_valid", 32'(ser_valid_a), 32'd1);
`endif

    // Random traffic against the model, with one reset in the middle
    do_reset("rst6");
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset("rst_rand");
      rd = DATA_W'($urandom);
      case ($urandom_range(0, 3))
        0: rd = 8'hD1;
        1: rd = 8'hDB;
        default: ;
      endcase
      tick(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
